// File: rtl/oled_pkg.sv
// Shared constants, state encoding and helpers for the OLED SPI arbiter.
package oled_pkg;

    localparam int unsigned OLED_DW      = 10;
    localparam int unsigned OLED_NREQ    = 3;
    localparam int unsigned OLED_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } oled_state_e;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oled_spi_arbiter_if.sv
// Requester-side and spi_write-side bus of the OLED SPI arbiter.
interface oled_spi_arbiter_if
    import oled_pkg::*;
#(
    parameter int unsigned NREQ = OLED_NREQ,
    parameter int unsigned DW   = OLED_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               spi_write_start;
    logic [DW-1:0]      spi_data;
    logic               spi_write_done;
    logic               busy;
    logic               timeout_err;

    // Arbiter side.
    modport slave (
        input  req, lock, req_data, spi_write_done,
        output gnt, ack, spi_write_start, spi_data, busy, timeout_err
    );

    // Requesters plus spi_write side.
    modport master (
        output req, lock, req_data, spi_write_done,
        input  gnt, ack, spi_write_start, spi_data, busy, timeout_err
    );
endinterface

// File: rtl/oled_rr_pick.sv
// Combinational round-robin selector: first requester after rr_ptr wins.
module oled_rr_pick
    import oled_pkg::*;
#(
    parameter  int unsigned NREQ = OLED_NREQ,
    localparam int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [IW-1:0]   win_idx_o,
    output logic            any_req_o
);

    int unsigned idx_c;

    // Scan slots rr_ptr+1 .. rr_ptr+NREQ (wrapping); the first requester found wins.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        any_req_o = 1'b0;
        idx_c     = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx_c = (32'(rr_ptr_i) + k) % NREQ;
            if (!any_req_o && req_i[IW'(idx_c)]) begin
                any_req_o             = 1'b1;
                win_idx_o             = IW'(idx_c);
                win_oh_o[IW'(idx_c)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Word-by-word round-robin arbiter sharing spi_write, with locked bursts and done timeout.
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned NREQ    = OLED_NREQ,
    parameter int unsigned DW      = OLED_DW,
    parameter int unsigned TIMEOUT = OLED_TIMEOUT
) (
    input logic               clk_1m,
    input logic               RST_n,
    oled_spi_arbiter_if.slave bus
);

    localparam int unsigned IW = idx_w(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    oled_state_e     state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            start_q, start_d;
    logic [DW-1:0]   data_q, data_d;
    logic            busy_q, busy_d;
    logic            terr_q, terr_d;

    logic [NREQ-1:0] win_oh_c;
    logic [IW-1:0]   win_idx_c;
    logic            any_req_c;
    logic [CW-1:0]   cnt_inc_c;
    logic            expire_c;
    logic            burst_c;
    logic [DW-1:0]   words_c [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_word
        assign words_c[g] = bus.req_data[g*DW +: DW];
    end

    oled_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i     (bus.req),
        .rr_ptr_i  (rr_ptr_q),
        .win_oh_o  (win_oh_c),
        .win_idx_o (win_idx_c),
        .any_req_o (any_req_c)
    );

    assign cnt_inc_c = cnt_q + CW'(1);
    assign expire_c  = (cnt_inc_c == CW'(TIMEOUT));
    assign burst_c   = bus.lock[owner_q] & bus.req[owner_q];

    // State register.
    always_ff @(posedge clk_1m) begin
        if (RST_n) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; done outside WAIT is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req_c) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.spi_write_done) state_d = ST_HOLD;
                else if (expire_c)      state_d = ST_IDLE;
            end
            ST_HOLD:  state_d = burst_c ? ST_START : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, owner, round-robin pointer and counter.
    always_comb begin
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        data_d   = data_q;
        ack_d    = '0;
        start_d  = 1'b0;
        terr_d   = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    owner_d = win_idx_c;
                    gnt_d   = win_oh_c;
                    data_d  = words_c[win_idx_c];
                    start_d = 1'b1;
                end
            end
            ST_START: cnt_d = '0;
            ST_WAIT: begin
                if (bus.spi_write_done) begin
                    ack_d = gnt_q;
                end else begin
                    cnt_d = cnt_inc_c;
                    if (expire_c) begin
                        terr_d   = 1'b1;
                        gnt_d    = '0;
                        rr_ptr_d = owner_q;
                    end
                end
            end
            ST_HOLD: begin
                if (burst_c) begin
                    data_d  = words_c[owner_q];
                    start_d = 1'b1;
                end else begin
                    gnt_d    = '0;
                    rr_ptr_d = owner_q;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; rr_ptr resets so requester 0 wins first.
    always_ff @(posedge clk_1m) begin
        if (RST_n) begin
            owner_q  <= '0;
            rr_ptr_q <= IW'(NREQ - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.ack             = ack_q;
    assign bus.spi_write_start = start_q;
    assign bus.spi_data        = data_q;
    assign bus.busy            = busy_q;
    assign bus.timeout_err     = terr_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Self-checking bench for oled_spi_arbiter: directed table, hand sequences, random words.
module tb_oled_spi_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 10;
    localparam int TMO  = 20;
    localparam int NVEC = 13;

    typedef struct {
        bit              rst;      // reset first, then raise pend
        logic [NREQ-1:0] pend;     // requests raised after the reset
        logic [NREQ-1:0] raise;    // extra requests raised once the word starts
        int              dly;      // WAIT cycle carrying done (> TMO: never)
        bit              spur;     // done pulse during START
        bit              drop;     // owner drops req during WAIT
        bit              lock_nx;  // owner lock during its ack cycle
        bit              repend;   // owner req during its ack cycle
        int              exp_own;  // expected owner of this word
    } vec_t;

    logic clk_1m = 1'b0;
    logic RST_n;
    always #5 clk_1m = ~clk_1m;

    oled_spi_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus_if ();

    oled_spi_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk_1m (clk_1m),
        .RST_n  (RST_n),
        .bus    (bus_if)
    );

    int              vectors    = 0;
    int              miscompares = 0;
    int              cyc        = 0;
    int              exp_cyc;
    int              last_owner;
    int              burst_own;
    bit              rnd_lock   = 1'b0;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] lock_v;
    logic [DW-1:0]   word_q [NREQ];
    vec_t            tbl [NVEC];

    always @(posedge clk_1m) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_1m);
        #1;
    endtask

    task automatic drive();
        bus_if.req  = pend;
        bus_if.lock = lock_v;
        for (int i = 0; i < NREQ; i++) bus_if.req_data[i*DW +: DW] = word_q[i];
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    // Round-robin reference: first pending requester after the last released owner.
    function automatic int rr_next(input int last, input logic [NREQ-1:0] p);
        for (int k = 1; k <= NREQ; k++)
            if (p[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic do_reset();
        pend = '0;
        lock_v = '0;
        word_q[0] = 10'h2AE;
        word_q[1] = 10'h100;
        word_q[2] = 10'h3C5;
        bus_if.spi_write_done = 1'b0;
        drive();
        RST_n = 1'b1;
        step();
        chk("reset_outs", 32'({bus_if.gnt, bus_if.ack, bus_if.spi_write_start,
                               bus_if.busy, bus_if.timeout_err}), 32'(0));
        chk("reset_data", 32'(bus_if.spi_data), 32'(0));
        RST_n = 1'b0;
        last_owner = NREQ - 1;
        burst_own  = -1;
    endtask

    // Carry one word from its start pulse to completion or abort.
    task automatic serve(input int own, input int dly, input bit spur, input bit drop,
                         input bit lock_nx, input bit repend, input logic [NREQ-1:0] raise);
        int              n;
        bit              quiet;
        logic [NREQ-1:0] g;
        logic [DW-1:0]   w;
        g = oh(own);
        w = word_q[own];
        n = 0;
        do begin
            step();
            n++;
        end while (bus_if.spi_write_start !== 1'b1 && n < 40);
        if (bus_if.spi_write_start !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL start_seen: no start within 40 cycles, required owner %0d", own);
            return;
        end
        chk("start_cycle", 32'(cyc), 32'(exp_cyc));
        chk("start_gnt", 32'(bus_if.gnt), 32'(g));
        chk("start_data", 32'(bus_if.spi_data), 32'(w));
        chk("start_flags", 32'({bus_if.busy, bus_if.ack, bus_if.timeout_err}), 32'({1'b1, 3'b000, 1'b0}));
        pend = pend | raise;
        if (drop) pend[own] = 1'b0;
        if (rnd_lock) lock_v = NREQ'($urandom);
        drive();
        quiet = 1'b1;
        for (int k = 1; k <= ((dly > TMO) ? TMO : dly); k++) begin
            if (k == 1 && spur) bus_if.spi_write_done = 1'b1;
            step();
            bus_if.spi_write_done = 1'b0;
            if (bus_if.spi_write_start !== 1'b0 || bus_if.ack !== '0 || bus_if.gnt !== g ||
                bus_if.spi_data !== w || bus_if.timeout_err !== 1'b0 || bus_if.busy !== 1'b1)
                quiet = 1'b0;
        end
        chk("wait_quiet", 32'(quiet), 32'(1));
        if (dly > TMO) begin
            step();
            chk("to_pulse", 32'({bus_if.timeout_err, bus_if.busy, bus_if.spi_write_start}), 32'(3'b100));
            chk("to_gnt_ack", 32'({bus_if.gnt, bus_if.ack}), 32'(0));
            last_owner = own;
            burst_own  = -1;
            exp_cyc    = cyc + 1;
            return;
        end
        bus_if.spi_write_done = 1'b1;
        step();
        bus_if.spi_write_done = 1'b0;
        chk("ack", 32'(bus_if.ack), 32'(g));
        chk("ack_gnt", 32'({bus_if.gnt, bus_if.spi_write_start, bus_if.timeout_err}), 32'({g, 2'b00}));
        word_q[own] = word_q[own] + DW'(1);
        pend[own]   = repend;
        lock_v[own] = lock_nx;
        drive();
        if (repend && lock_nx) begin
            burst_own = own;
            exp_cyc   = cyc + 1;
            return;
        end
        step();
        chk("release", 32'({bus_if.gnt, bus_if.ack, bus_if.busy, bus_if.spi_write_start}), 32'(0));
        last_owner = own;
        burst_own  = -1;
        exp_cyc    = cyc + 1;
    endtask

    initial begin
        //          rst   pend    raise   dly  spur  drop  lock  rep   own
        tbl[0]  = '{1'b1, 3'b001, 3'b000, 16,  1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 3'b111, 3'b000, 16,  1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[2]  = '{1'b0, 3'b000, 3'b000, 3,   1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[3]  = '{1'b0, 3'b000, 3'b000, TMO, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[4]  = '{1'b0, 3'b000, 3'b000, 1,   1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[5]  = '{1'b0, 3'b000, 3'b000, 7,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b0, 3'b000, 3'b000, 16,  1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[7]  = '{1'b1, 3'b010, 3'b001, 16,  1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[8]  = '{1'b0, 3'b000, 3'b000, 5,   1'b0, 1'b1, 1'b1, 1'b1, 1};
        tbl[9]  = '{1'b0, 3'b000, 3'b000, 16,  1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[10] = '{1'b0, 3'b000, 3'b000, 16,  1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b1, 3'b100, 3'b000, 99,  1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[12] = '{1'b0, 3'b000, 3'b000, TMO, 1'b0, 1'b0, 1'b0, 1'b0, 2};

        RST_n = 1'b1;
        bus_if.spi_write_done = 1'b0;

        // Directed table: single word, fairness, locked burst, timeout and its boundary.
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].rst) begin
                do_reset();
                pend = tbl[i].pend;
                drive();
                exp_cyc = cyc + 1;
            end
            serve(tbl[i].exp_own, tbl[i].dly, tbl[i].spur, tbl[i].drop,
                  tbl[i].lock_nx, tbl[i].repend, tbl[i].raise);
        end

        // Done strobes while idle are ignored.
        do_reset();
        bus_if.spi_write_done = 1'b1;
        step();
        bus_if.spi_write_done = 1'b0;
        chk("spur_idle", 32'({bus_if.gnt, bus_if.ack, bus_if.busy, bus_if.spi_write_start,
                              bus_if.timeout_err}), 32'(0));
        step();
        chk("spur_idle2", 32'({bus_if.gnt, bus_if.ack, bus_if.busy, bus_if.spi_write_start,
                               bus_if.timeout_err}), 32'(0));

        // Reset while a word is in WAIT, then a lone req2 is served normally.
        do_reset();
        pend = 3'b001;
        drive();
        step();
        chk("rst_mid_start", 32'({bus_if.spi_write_start, bus_if.gnt}), 32'({1'b1, 3'b001}));
        step();
        step();
        step();
        RST_n = 1'b1;
        step();
        chk("rst_mid_outs", 32'({bus_if.gnt, bus_if.ack, bus_if.spi_write_start,
                                 bus_if.busy, bus_if.timeout_err}), 32'(0));
        chk("rst_mid_data", 32'(bus_if.spi_data), 32'(0));
        RST_n = 1'b0;
        pend = '0;
        drive();
        step();
        chk("rst_mid_idle", 32'({bus_if.gnt, bus_if.ack, bus_if.busy, bus_if.spi_write_start,
                                 bus_if.timeout_err}), 32'(0));
        last_owner = NREQ - 1;
        burst_own  = -1;
        pend = 3'b100;
        drive();
        exp_cyc = cyc + 1;
        serve(2, 16, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Random words against the transaction-level model.
        do_reset();
        for (int i = 0; i < NREQ; i++) word_q[i] = DW'($urandom);
        pend = 3'b111;
        drive();
        exp_cyc  = cyc + 1;
        rnd_lock = 1'b1;
        for (int it = 0; it < 60; it++) begin
            int e, d, r;
            bit sp, dr, lk, rp;
            logic [NREQ-1:0] rs;
            e  = (burst_own >= 0) ? burst_own : rr_next(last_owner, pend);
            r  = int'($urandom_range(0, 9));
            d  = (r == 0) ? TMO + 1 + int'($urandom_range(0, 5)) : int'($urandom_range(1, TMO));
            sp = ($urandom_range(0, 3) == 0);
            dr = ($urandom_range(0, 4) == 0);
            lk = ($urandom_range(0, 1) == 1);
            rp = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
            serve(e, d, sp, dr, lk, rp, rs);
            if (pend == '0) begin
                pend = NREQ'($urandom_range(1, 7));
                drive();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
